// File: rtl/snn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snn_pkg                                                              |
// | Opcodes, bus command record and loader state encoding.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package snn_pkg;

    localparam int SNN_ADDR_W = 3;
    localparam int SNN_CMD_W  = 3;
    localparam int SNN_ARG_W  = 8;

    localparam logic [SNN_CMD_W-1:0] CMD_NOP        = 3'd0;
    localparam logic [SNN_CMD_W-1:0] CMD_SET_W1     = 3'd1;
    localparam logic [SNN_CMD_W-1:0] CMD_SET_W2     = 3'd2;
    localparam logic [SNN_CMD_W-1:0] CMD_SET_THRESH = 3'd3;
    localparam logic [SNN_CMD_W-1:0] CMD_CLR_POT    = 3'd4;

    typedef struct packed {
        logic [SNN_ADDR_W-1:0] addr;
        logic [SNN_CMD_W-1:0]  cmd;
        logic [SNN_ARG_W-1:0]  arg;
    } snn_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/snn_cmd_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snn_cmd_loader_if                                                    |
// | Table write port, replay handshake and configuration bus.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface snn_cmd_loader_if #(
    parameter int ADDR_WIDTH  = 3,
    parameter int CMD_WIDTH   = 3,
    parameter int FLOAT_WIDTH = 8,
    parameter int DEPTH       = 16
);
    logic                       wr_en;
    logic [$clog2(DEPTH)-1:0]   wr_idx;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [CMD_WIDTH-1:0]       wr_cmd;
    logic [FLOAT_WIDTH-1:0]     wr_arg;
    logic [$clog2(DEPTH):0]     n_entries;
    logic                       start;
    logic                       abort;
    logic                       busy;
    logic                       done;
    logic                       aborted;
    logic                       wr_err;
    logic [ADDR_WIDTH-1:0]      addr;
    logic [CMD_WIDTH-1:0]       cmd;
    logic [FLOAT_WIDTH-1:0]     cmd_arg;
    logic [FLOAT_WIDTH-1:0]     csum;

    modport master (
        output wr_en, wr_idx, wr_addr, wr_cmd, wr_arg, n_entries, start, abort,
        input  busy, done, aborted, wr_err, addr, cmd, cmd_arg, csum
    );

    modport slave (
        input  wr_en, wr_idx, wr_addr, wr_cmd, wr_arg, n_entries, start, abort,
        output busy, done, aborted, wr_err, addr, cmd, cmd_arg, csum
    );
endinterface
`default_nettype wire

// File: rtl/snn_cmd_table.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snn_cmd_table                                                        |
// | Command register file: one synchronous write, one async read.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module snn_cmd_table
    import snn_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IDX_WIDTH = $clog2(DEPTH)
) (
    input  wire logic                 clk,
    input  wire logic                 i_wr_en,
    input  wire logic [IDX_WIDTH-1:0] i_wr_idx,
    input  wire snn_cmd_t             i_wr_data,
    input  wire logic [IDX_WIDTH-1:0] i_rd_idx,
    output snn_cmd_t                  o_rd_data
);
    // Contents are deliberately not reset; software loads them before use.
    snn_cmd_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];
endmodule
`default_nettype wire

// File: rtl/snn_cmd_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snn_cmd_loader                                                       |
// | Replays a command table onto the neuron configuration bus.           |
// | Optional argument checksum: define SNN_LOADER_CSUM_EN.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module snn_cmd_loader
    import snn_pkg::*;
#(
    parameter int INT_WIDTH   = 4,
    parameter int FLOAT_WIDTH = 2 * INT_WIDTH,
    parameter int CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH  = 3,
    parameter int DEPTH       = 16,
    parameter int GAP_CYCLES  = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    snn_cmd_loader_if.slave bus
);
    localparam int                 c_idx_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [3:0]         c_gap_last = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit                 c_has_gap  = (GAP_CYCLES > 0);

    loader_state_t          r_state;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_cnt_w-1:0]     r_left;
    logic [3:0]             r_gap_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_aborted;
    logic                   r_wr_err;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [CMD_WIDTH-1:0]   r_cmd;
    logic [FLOAT_WIDTH-1:0] r_arg;

    logic                   w_idle;
    logic                   w_tbl_we;
    logic                   w_more;
    logic                   w_abort;
    logic [c_cnt_w-1:0]     w_n_clamped;
    logic [c_idx_w-1:0]     w_next_idx;
    logic [c_idx_w-1:0]     w_rd_idx;
    snn_cmd_t               w_wr_entry;
    snn_cmd_t               w_rd_entry;
    snn_cmd_t               w_first_entry;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_tbl_we    = bus.wr_en && w_idle;
    assign w_more      = (r_left != '0);
    assign w_abort     = bus.abort && ((r_state == ST_ISSUE) || (r_state == ST_GAP));
    assign w_n_clamped = (bus.n_entries > c_depth) ? c_depth : bus.n_entries;
    assign w_next_idx  = r_idx + c_idx_w'(1);
    assign w_rd_idx    = w_idle ? '0 : w_next_idx;
    assign w_wr_entry  = '{addr: bus.wr_addr, cmd: bus.wr_cmd, arg: bus.wr_arg};
    // A write to entry 0 in the start cycle must be the one issued first.
    assign w_first_entry = (w_tbl_we && (bus.wr_idx == '0)) ? w_wr_entry : w_rd_entry;

    snn_cmd_table #(.DEPTH(DEPTH)) u_table (
        .clk       (clk),
        .i_wr_en   (w_tbl_we),
        .i_wr_idx  (bus.wr_idx),
        .i_wr_data (w_wr_entry),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_entry)
    );

    // Bus registers default to NOP each cycle; only the edge entering ISSUE loads an entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_left    <= '0;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_wr_err  <= 1'b0;
            r_addr    <= '0;
            r_cmd     <= CMD_NOP;
            r_arg     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_wr_err  <= bus.wr_en && !w_idle;
            r_addr    <= '0;
            r_cmd     <= CMD_NOP;
            r_arg     <= '0;
            if (w_abort) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_idx  <= '0;
                            r_busy <= 1'b1;
                            if (w_n_clamped != '0) begin
                                r_state <= ST_ISSUE;
                                r_left  <= w_n_clamped - c_cnt_w'(1);
                                r_addr  <= w_first_entry.addr;
                                r_cmd   <= w_first_entry.cmd;
                                r_arg   <= w_first_entry.arg;
                            end else begin
                                r_state <= ST_FINISH;
                                r_left  <= '0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_ISSUE, ST_GAP: begin
                        if ((r_state == ST_ISSUE) && c_has_gap) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= c_gap_last;
                        end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
                            r_gap_cnt <= r_gap_cnt - 4'd1;
                        end else if (w_more) begin
                            r_state <= ST_ISSUE;
                            r_idx   <= w_next_idx;
                            r_left  <= r_left - c_cnt_w'(1);
                            r_addr  <= w_rd_entry.addr;
                            r_cmd   <= w_rd_entry.cmd;
                            r_arg   <= w_rd_entry.arg;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_FINISH: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SNN_LOADER_CSUM_EN
    logic [FLOAT_WIDTH-1:0] r_csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= '0;
        end else if (w_idle && bus.start) begin
            r_csum <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_csum <= r_csum ^ r_arg;
        end
    end

    assign bus.csum = r_csum;
`else
    assign bus.csum = '0;
`endif

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.aborted = r_aborted;
    assign bus.wr_err  = r_wr_err;
    assign bus.addr    = r_addr;
    assign bus.cmd     = r_cmd;
    assign bus.cmd_arg = r_arg;
endmodule
`default_nettype wire

// File: tb/tb_snn_cmd_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_snn_cmd_loader                                                    |
// | Self-checking bench: GAP_CYCLES=1 and GAP_CYCLES=0 loaders.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_snn_cmd_loader;
    import snn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    snn_cmd_loader_if #(.ADDR_WIDTH(3), .CMD_WIDTH(3), .FLOAT_WIDTH(8), .DEPTH(16)) b1 ();
    snn_cmd_loader_if #(.ADDR_WIDTH(3), .CMD_WIDTH(3), .FLOAT_WIDTH(8), .DEPTH(16)) b0 ();

    snn_cmd_loader #(.GAP_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    snn_cmd_loader #(.GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    typedef struct packed {
        logic     busy;
        logic     done;
        snn_cmd_t c;
    } exp_t;

    typedef struct packed {
        bit use0;
        int n;
        int exp_len;
    } vec_t;

    exp_t     q1[$];
    exp_t     q0[$];
    exp_t     e1;
    exp_t     e0;
    snn_cmd_t model [16];
    snn_cmd_t we;
    vec_t     vecs [7];
    int       n_checks  = 0;
    int       n_fail    = 0;
    int       cyc       = 0;
    int       start_cyc = 0;
    int       done_cyc1 = -1;
    int       done_cyc0 = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: one expected record per cycle while a replay is outstanding.
    always @(negedge clk) begin
        if (b1.done) done_cyc1 = cyc;
        if (b0.done) done_cyc0 = cyc;
        if (q1.size() != 0) begin
            e1 = q1.pop_front();
            check("trace_gap1", 32'({b1.busy, b1.done, b1.addr, b1.cmd, b1.cmd_arg}), 32'(e1));
        end
        if (q0.size() != 0) begin
            e0 = q0.pop_front();
            check("trace_gap0", 32'({b0.busy, b0.done, b0.addr, b0.cmd, b0.cmd_arg}), 32'(e0));
        end
    end

    task automatic push(input bit use0, input exp_t e);
        if (use0) q0.push_back(e);
        else      q1.push_back(e);
    endtask

    task automatic push_trace(input bit use0, input int n);
        int   nn  = (n > 16) ? 16 : n;
        int   gap = use0 ? 0 : 1;
        exp_t e;
        exp_t nop;
        nop.busy = 1'b1; nop.done = 1'b0;
        nop.c.addr = '0; nop.c.cmd = CMD_NOP; nop.c.arg = '0;
        for (int k = 0; k < nn; k++) begin
            e.busy = 1'b1; e.done = 1'b0; e.c = model[k];
            push(use0, e);
            for (int g = 0; g < gap; g++) push(use0, nop);
        end
        e = nop; e.done = 1'b1;
        push(use0, e);
        e = nop; e.busy = 1'b0;
        push(use0, e);
    endtask

    function automatic logic [7:0] exp_csum(input int n);
        logic [7:0] x = '0;
        for (int k = 0; k < ((n > 16) ? 16 : n); k++) x ^= model[k].arg;
`ifndef SNN_LOADER_CSUM_EN
        x = '0;
`endif
        return x;
    endfunction

    task automatic drive_wr(input bit en, input bit only1, input int idx, input snn_cmd_t e);
        b1.wr_en = en;          b0.wr_en = en && !only1;
        b1.wr_idx = 4'(idx);    b0.wr_idx = 4'(idx);
        b1.wr_addr = e.addr;    b0.wr_addr = e.addr;
        b1.wr_cmd = e.cmd;      b0.wr_cmd = e.cmd;
        b1.wr_arg = e.arg;      b0.wr_arg = e.arg;
    endtask

    task automatic write_entry(input int idx, input snn_cmd_t e);
        @(posedge clk); #1;
        drive_wr(1'b1, 1'b0, idx, e);
        model[idx] = e;
        @(posedge clk); #1;
        drive_wr(1'b0, 1'b0, 0, e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    // Optional same-cycle write to entry 0 exercises the start/write ordering.
    task automatic do_replay(input bit use0, input int n, input int exp_len,
                             input bit with_wr, input snn_cmd_t wr_e);
        int dc;
        @(posedge clk); #1;
        if (with_wr) begin
            drive_wr(1'b1, 1'b0, 0, wr_e);
            model[0] = wr_e;
        end
        if (use0) begin b0.start = 1'b1; b0.n_entries = 5'(n); done_cyc0 = -1; end
        else      begin b1.start = 1'b1; b1.n_entries = 5'(n); done_cyc1 = -1; end
        @(posedge clk);
        push_trace(use0, n);
        #1;
        start_cyc = cyc;
        b0.start = 1'b0;
        b1.start = 1'b0;
        drive_wr(1'b0, 1'b0, 0, wr_e);
        wait_drain();
        dc = use0 ? done_cyc0 : done_cyc1;
        check($sformatf("done_latency_n%0d_g%0d", n, use0 ? 0 : 1), 32'(dc - start_cyc + 1), 32'(exp_len));
        check("csum", 32'(use0 ? b0.csum : b1.csum), 32'(exp_csum(n)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    32'(b1.busy),    32'd0);
        check({tag, "_done"},    32'(b1.done),    32'd0);
        check({tag, "_aborted"}, 32'(b1.aborted), 32'd0);
        check({tag, "_wr_err"},  32'(b1.wr_err),  32'd0);
        check({tag, "_bus"},     32'({b1.addr, b1.cmd, b1.cmd_arg}), 32'({3'd0, CMD_NOP, 8'd0}));
        check({tag, "_csum"},    32'(b1.csum),    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs = '{'{1'b0, 0, 1}, '{1'b0, 1, 3}, '{1'b0, 2, 5}, '{1'b1, 5, 6},
                 '{1'b1, 16, 17}, '{1'b1, 17, 17}, '{1'b1, 0, 1}};
        we = '0;
        drive_wr(1'b0, 1'b0, 0, we);
        b1.start = 1'b0; b0.start = 1'b0; b1.abort = 1'b0; b0.abort = 1'b0;
        b1.n_entries = '0; b0.n_entries = '0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_gap0_bus", 32'({b0.busy, b0.addr, b0.cmd, b0.cmd_arg}), 32'd0);
        @(negedge clk) rst = 1'b1;

        for (int k = 0; k < 16; k++) begin
            if (k == 0)      we = '{addr: 3'd1, cmd: CMD_SET_W1,     arg: 8'h10};
            else if (k == 1) we = '{addr: 3'd2, cmd: CMD_SET_W2,     arg: 8'h0C};
            else if (k == 2) we = '{addr: 3'd3, cmd: CMD_SET_THRESH, arg: 8'h18};
            else             we = '{addr: 3'(k), cmd: 3'(1 + k % 4), arg: 8'(k * 37 + 5)};
            write_entry(k, we);
        end

        do_replay(1'b0, 3, 7, 1'b0, we);
`ifdef SNN_LOADER_CSUM_EN
        check("csum_plan", 32'(b1.csum), 32'h04);
`else
        check("csum_plan", 32'(b1.csum), 32'h00);
`endif

        for (int i = 0; i < 7; i++) do_replay(vecs[i].use0, vecs[i].n, vecs[i].exp_len, 1'b0, we);

        we = '{addr: 3'd5, cmd: CMD_CLR_POT, arg: 8'hA5};
        do_replay(1'b0, 2, 5, 1'b1, we);

        // Abort while entry 1 of 3 is on the bus.
        @(posedge clk); #1;
        b1.start = 1'b1; b1.n_entries = 5'd3; done_cyc1 = -1;
        @(posedge clk); #1 b1.start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("abort_pre_bus", 32'({b1.addr, b1.cmd, b1.cmd_arg}), 32'(model[1]));
        b1.abort = 1'b1;
        @(posedge clk); #1 b1.abort = 1'b0;
        check("abort_bus_nop", 32'({b1.addr, b1.cmd, b1.cmd_arg}), 32'd0);
        check("abort_pulse",   32'(b1.aborted), 32'd1);
        check("abort_busy",    32'(b1.busy),    32'd0);
        @(posedge clk); #1;
        check("abort_pulse_end", 32'(b1.aborted), 32'd0);
        repeat (6) @(posedge clk);
        check("abort_no_done", 32'(done_cyc1 + 1), 32'd0);

        @(posedge clk); #1 b1.abort = 1'b1;
        @(posedge clk); #1 b1.abort = 1'b0;
        check("abort_idle_ignored", 32'({b1.aborted, b1.busy}), 32'd0);

        // Write and start while busy: both rejected, replay uses the original table.
        @(posedge clk); #1;
        b1.start = 1'b1; b1.n_entries = 5'd3; done_cyc1 = -1;
        @(posedge clk);
        push_trace(1'b0, 3);
        #1;
        start_cyc = cyc;
        b1.n_entries = 5'd1;
        we = '{addr: 3'd7, cmd: CMD_CLR_POT, arg: 8'hFF};
        drive_wr(1'b1, 1'b1, 1, we);
        @(posedge clk); #1;
        drive_wr(1'b0, 1'b0, 0, we);
        b1.start = 1'b0;
        check("wr_err_pulse", 32'(b1.wr_err), 32'd1);
        @(posedge clk); #1;
        check("wr_err_end", 32'(b1.wr_err), 32'd0);
        wait_drain();
        check("wr_err_latency", 32'(done_cyc1 - start_cyc + 1), 32'd7);
        do_replay(1'b0, 3, 7, 1'b0, we);

        // Asynchronous reset in the middle of a gap cycle.
        @(posedge clk); #1;
        b1.start = 1'b1; b1.n_entries = 5'd3;
        @(posedge clk); #1 b1.start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(b1.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk) rst = 1'b1;
        do_replay(1'b0, 3, 7, 1'b0, we);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/snn_cmd_loader.md
# snn_cmd_loader

Command initiator for the spiking network configuration bus. Holds a small table of configuration commands (neuron address, opcode, fixed-point argument). On `start` it replays the table onto the shared `addr`/`cmd`/`cmd_arg` bus that every `spiking_neuron_2in` listens to. It sits beside a network top such as the XOR network and loads weights and thresholds before a run, with a start/busy/done handshake toward the controlling logic.

## Interface
- `INT_WIDTH`, 4: integer part width; matches the neurons.
- `FLOAT_WIDTH`, 2*INT_WIDTH: width of `cmd_arg` and table argument field.
- `CMD_WIDTH`, 3: opcode width.
- `ADDR_WIDTH`, 3: neuron global-ID width.
- `DEPTH`, 16: table entries (power of two).
- `GAP_CYCLES`, 1: NOP cycles after each issued command (0..15).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: table write strobe.
- `wr_idx` in $clog2(DEPTH): table index to write.
- `wr_addr` in ADDR_WIDTH: entry neuron address.
- `wr_cmd` in CMD_WIDTH: entry opcode.
- `wr_arg` in FLOAT_WIDTH: entry argument.
- `n_entries` in $clog2(DEPTH)+1: entries to issue, 0..DEPTH; sampled at `start`.
- `start` in 1: begin replay (one-cycle pulse).
- `abort` in 1: stop replay.
- `busy` out 1: replay in progress.
- `done` out 1: one-cycle pulse when replay completes.
- `aborted` out 1: one-cycle pulse when replay is stopped by `abort`.
- `wr_err` out 1: one-cycle pulse when a write is rejected.
- `addr` out ADDR_WIDTH: bus neuron address.
- `cmd` out CMD_WIDTH: bus opcode.
- `cmd_arg` out FLOAT_WIDTH: bus argument.
- `csum` out FLOAT_WIDTH: argument checksum (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, GAP, FINISH.
- IDLE:
  - `wr_en` writes the entry at `wr_idx`.
  - `start` latches `n_entries` (values > DEPTH clamp to DEPTH) and clears the entry index.
  - With a nonzero count, `start` moves to ISSUE; with zero it moves to FINISH.
- ISSUE: drives the entry at the current index onto the bus for exactly one cycle, then:
  - to GAP if GAP_CYCLES > 0;
  - else to ISSUE with the next index if entries remain;
  - else to FINISH.
- GAP: drives `cmd`=CMD_NOP, `addr`=0, `cmd_arg`=0 for GAP_CYCLES cycles, then:
  - to ISSUE with the next index if entries remain;
  - else to FINISH.
- FINISH: pulses `done` for one cycle, then returns to IDLE.
- Outside ISSUE, the bus always carries CMD_NOP/0/0.
- `busy` = (state != IDLE).
- `start` while busy is ignored.
- `wr_en` while busy: no write; `wr_err` pulses the next cycle; table unchanged.
- `abort` while busy (any state except FINISH):
  - the next state is IDLE and the bus is NOP from the next cycle;
  - `aborted` pulses for one cycle; `done` does not pulse.
  - `abort` in FINISH or IDLE is ignored.
- Simultaneous `start` and `abort` in IDLE: `start` wins.
- Simultaneous `start` and `wr_en` in IDLE: the write completes first; a write to index 0 is the one issued.
- The table has no reset. Its contents are undefined until written.

## Timing
- Reset values:
  - `busy`, `done`, `aborted`, `wr_err` = 0;
  - `addr` = 0, `cmd` = CMD_NOP, `cmd_arg` = 0, `csum` = 0;
  - state IDLE.
- Reset mid-replay takes effect immediately (asynchronously), forcing these values.
- All outputs are registered.
- With `start` sampled at edge T:
  - entry k is on the bus during cycle T+1+k*(1+GAP_CYCLES);
  - `done` is high during cycle T+1+N*(1+GAP_CYCLES);
  - with N=0, `done` is high during T+1.
- `busy` is high from T+1 through the `done` cycle inclusive. A new `start` is accepted in the cycle after `done`.
- `wr_err` and `aborted` go high in the cycle following the offending sample edge.

## Configuration
- `SNN_LOADER_CSUM_EN` defined:
  - `csum` clears at accepted `start`;
  - `csum` XOR-accumulates each issued `cmd_arg` in its ISSUE cycle;
  - `csum` is stable from the `done` cycle until the next `start`.
- Not defined: `csum` is tied to 0 and no accumulator is built.

## Structure
- Package `snn_pkg` holds:
  - opcodes: CMD_NOP=0, CMD_SET_W1=1, CMD_SET_W2=2, CMD_SET_THRESH=3, CMD_CLR_POT=4;
  - typedef `snn_cmd_t` packing {addr, cmd, arg};
  - the loader state enum.
- One sub-module: `snn_cmd_table`, a DEPTH-entry register file with one synchronous write port and one combinational read port of `snn_cmd_t`.

## Test plan
- Write 3 entries {1,SET_W1,0x10}, {2,SET_W2,0x0C}, {3,SET_THRESH,0x18}; GAP_CYCLES=1; `start` at T with n_entries=3:
  - entries appear at T+1, T+3, T+5;
  - NOP at T+2, T+4, T+6;
  - `done` at T+7;
  - with CSUM_EN, `csum`=0x04.
- n_entries=0 -> `done` at T+1 and `busy` high only in T+1; no bus activity.
- `abort` asserted at the ISSUE edge of entry 1 of 3:
  - bus NOP next cycle;
  - `aborted` pulses once, `done` never, `busy` low after it.
- `wr_en` while busy -> `wr_err` pulses; readback replay shows the original entry unchanged.
- `rst` low mid-GAP -> outputs go to reset values immediately. After release, IDLE: `start` with the table unchanged replays correctly.
- n_entries=DEPTH+1, GAP_CYCLES=0 -> DEPTH back-to-back entries, index wraps cleanly, `done` at T+1+DEPTH.
